// File: rtl/arm_pkg.sv
// arm_pkg: shared ARM decode constants for the execute stage and branch unit.
//   - data-processing opcode encodings
//   - condition-field encodings
//   - NZCV flag bit indices
//   - cond_pass(): evaluates a condition field against an NZCV value
package arm_pkg;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpRsb = 4'b0011;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpRsc = 4'b0111;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpTeq = 4'b1001;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpCmn = 4'b1011;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpBic = 4'b1110;
  localparam logic [3:0] OpMvn = 4'b1111;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    n = nzcv[FlagN];
    z = nzcv[FlagZ];
    c = nzcv[FlagC];
    v = nzcv[FlagV];
    unique case (cond)
      CondEq:  pass = z;
      CondNe:  pass = ~z;
      CondCs:  pass = c;
      CondCc:  pass = ~c;
      CondMi:  pass = n;
      CondPl:  pass = ~n;
      CondVs:  pass = v;
      CondVc:  pass = ~v;
      CondHi:  pass = c & ~z;
      CondLs:  pass = ~c | z;
      CondGe:  pass = (n == v);
      CondLt:  pass = (n != v);
      CondGt:  pass = ~z & (n == v);
      CondLe:  pass = z | (n != v);
      CondAl:  pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
//   slave  : the execute stage (consumes *_In, drives *_Out)
//   master : the surrounding pipeline (drives *_In, consumes *_Out)
interface ex_mem_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
);
  logic [3:0]    ALU_In;
  logic          S_In;
  logic          rf_In;
  logic          Load_In;
  logic          Size_In;
  logic          Enable_In;
  logic          rw_In;
  logic [3:0]    Cond_In;
  logic [DW-1:0] A_In;
  logic [DW-1:0] B_In;
  logic          Shift_C_In;
  logic [DW-1:0] StoreData_In;
  logic [RW-1:0] Rd_In;

  logic [DW-1:0] ALU_Result_Out;
  logic [DW-1:0] StoreData_Out;
  logic [RW-1:0] Rd_Out;
  logic          rf_Out;
  logic          Load_Out;
  logic          Size_Out;
  logic          Enable_Out;
  logic          rw_Out;
  logic [3:0]    Flags_Out;

  modport master (
    output ALU_In, S_In, rf_In, Load_In, Size_In, Enable_In, rw_In, Cond_In,
           A_In, B_In, Shift_C_In, StoreData_In, Rd_In,
    input  ALU_Result_Out, StoreData_Out, Rd_Out, rf_Out, Load_Out, Size_Out,
           Enable_Out, rw_Out, Flags_Out
  );

  modport slave (
    input  ALU_In, S_In, rf_In, Load_In, Size_In, Enable_In, rw_In, Cond_In,
           A_In, B_In, Shift_C_In, StoreData_In, Rd_In,
    output ALU_Result_Out, StoreData_Out, Rd_Out, rf_Out, Load_Out, Size_Out,
           Enable_Out, rw_Out, Flags_Out
  );
endinterface

// File: rtl/ex_alu.sv
// ex_alu: combinational ARM data-processing unit.
//   op_i      : ARM opcode
//   a_i, b_i  : Rn operand and shifter operand
//   shift_c_i : shifter carry-out (C for logical ops)
//   c_i, v_i  : current C and V flags (carry-in, V hold for logical ops)
//   result_o  : operation result
//   flags_o   : candidate NZCV for an S-suffixed instruction
module ex_alu
  import arm_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [3:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          shift_c_i,
  input  logic          c_i,
  input  logic          v_i,
  output logic [DW-1:0] result_o,
  output logic [3:0]    flags_o
);

  logic [DW-1:0] add_x, add_y, add_y_eff, logic_res;
  logic          invert, cin, arith;
  logic [DW:0]   sum;
  logic          add_v;

  // Operand routing for the shared adder; subtracts are X + ~Y + cin.
  always_comb begin
    add_x  = a_i;
    add_y  = b_i;
    invert = 1'b0;
    cin    = 1'b0;
    arith  = 1'b1;
    unique case (op_i)
      OpSub, OpCmp: begin
        invert = 1'b1;
        cin    = 1'b1;
      end
      OpRsb: begin
        add_x  = b_i;
        add_y  = a_i;
        invert = 1'b1;
        cin    = 1'b1;
      end
      OpAdd, OpCmn: cin = 1'b0;
      OpAdc:        cin = c_i;
      OpSbc: begin
        invert = 1'b1;
        cin    = c_i;
      end
      OpRsc: begin
        add_x  = b_i;
        add_y  = a_i;
        invert = 1'b1;
        cin    = c_i;
      end
      default: arith = 1'b0;
    endcase
  end

  assign add_y_eff = invert ? ~add_y : add_y;
  assign sum       = {1'b0, add_x} + {1'b0, add_y_eff} + {{DW{1'b0}}, cin};
  // Overflow: both addends share a sign that differs from the sum's sign.
  assign add_v     = (add_x[DW-1] == add_y_eff[DW-1]) && (sum[DW-1] != add_x[DW-1]);

  always_comb begin
    logic_res = '0;
    unique case (op_i)
      OpAnd, OpTst: logic_res = a_i & b_i;
      OpEor, OpTeq: logic_res = a_i ^ b_i;
      OpOrr:        logic_res = a_i | b_i;
      OpMov:        logic_res = b_i;
      OpBic:        logic_res = a_i & ~b_i;
      OpMvn:        logic_res = ~b_i;
      default:      logic_res = '0;
    endcase
  end

  always_comb begin
    result_o       = arith ? sum[DW-1:0] : logic_res;
    flags_o        = '0;
    flags_o[FlagN] = result_o[DW-1];
    flags_o[FlagZ] = (result_o == '0);
    flags_o[FlagC] = arith ? sum[DW] : shift_c_i;
    flags_o[FlagV] = arith ? add_v : v_i;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: ARM execute stage with the EX/MEM pipeline register and NZCV flags.
//   CLK   : rising-edge clock
//   CLR   : asynchronous active-high reset, clears every register
//   Flush : inserts a bubble (controls and data cleared, flags kept)
//   Stall : holds the EX/MEM register and the flags
//   bus   : ID/EX inputs (*_In) and registered EX/MEM outputs (*_Out), Flags_Out = {N,Z,C,V}
module ex_mem_stage
  import arm_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic           Flush,
  input  logic           Stall,
  ex_mem_stage_if.slave  bus
);

  logic [DW-1:0] alu_result;
  logic [3:0]    alu_flags;
  logic          cond_ok, is_test_op, rf_d, enable_d, flag_we;

  logic [DW-1:0] result_q, store_data_q;
  logic [RW-1:0] rd_q;
  logic          rf_q, load_q, size_q, enable_q, rw_q;
  logic [3:0]    flags_q;

  ex_alu #(
    .DW(DW)
  ) u_alu (
    .op_i      (bus.ALU_In),
    .a_i       (bus.A_In),
    .b_i       (bus.B_In),
    .shift_c_i (bus.Shift_C_In),
    .c_i       (flags_q[FlagC]),
    .v_i       (flags_q[FlagV]),
    .result_o  (alu_result),
    .flags_o   (alu_flags)
  );

  always_comb begin
    cond_ok    = cond_pass(bus.Cond_In, flags_q);
    // TST/TEQ/CMP/CMN only set flags; they never write a register.
    is_test_op = (bus.ALU_In[3:2] == 2'b10);
    rf_d       = bus.rf_In & cond_ok & ~is_test_op;
    enable_d   = bus.Enable_In & cond_ok;
    flag_we    = bus.S_In & cond_ok & ~Stall & ~Flush;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      result_q     <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      rf_q         <= 1'b0;
      load_q       <= 1'b0;
      size_q       <= 1'b0;
      enable_q     <= 1'b0;
      rw_q         <= 1'b0;
    end else if (Flush) begin
      result_q     <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      rf_q         <= 1'b0;
      load_q       <= 1'b0;
      size_q       <= 1'b0;
      enable_q     <= 1'b0;
      rw_q         <= 1'b0;
    end else if (!Stall) begin
      result_q     <= alu_result;
      store_data_q <= bus.StoreData_In;
      rd_q         <= bus.Rd_In;
      rf_q         <= rf_d;
      load_q       <= bus.Load_In;
      size_q       <= bus.Size_In;
      enable_q     <= enable_d;
      rw_q         <= bus.rw_In;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= alu_flags;
    end
  end

  assign bus.ALU_Result_Out = result_q;
  assign bus.StoreData_Out  = store_data_q;
  assign bus.Rd_Out         = rd_q;
  assign bus.rf_Out         = rf_q;
  assign bus.Load_Out       = load_q;
  assign bus.Size_Out       = size_q;
  assign bus.Enable_Out     = enable_q;
  assign bus.rw_Out         = rw_q;
  assign bus.Flags_Out      = flags_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed table, hand sequences and random stimulus against a
// behavioural model of the ARM execute stage.
module tb_ex_mem_stage;

  logic CLK = 1'b0;
  logic CLR, Flush, Stall;

  ex_mem_stage_if #(.DW(32), .RW(4)) bus ();

  ex_mem_stage #(
    .DW(32),
    .RW(4)
  ) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .Flush (Flush),
    .Stall (Stall),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  op, cond, rd;
    logic        s, rf, ld, sz, en, rw, shc, flush, stall;
    logic [31:0] a, b, sd;
  } in_t;

  typedef struct {
    logic [31:0] res, sd;
    logic [3:0]  rd, flags;
    logic        rf, ld, sz, en, rw;
  } st_t;

  typedef struct {
    in_t         in;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        rf, en;
  } vec_t;

  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  int   errors = 0;
  int   checks = 0;
  st_t  m;
  in_t  cur;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM condition table, written from the architectural definitions.
  function automatic logic cond_model(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // x - y - borrow in wide integer arithmetic; C means no borrow.
  function automatic void do_sub(input logic [31:0] x, input logic [31:0] y, input logic br,
                                 output logic [31:0] r, output logic c, output logic v);
    longint full, sfull;
    full  = longint'(x) - longint'(y) - longint'(br);
    sfull = longint'($signed(x)) - longint'($signed(y)) - longint'(br);
    r = full[31:0];
    c = (full >= 0);
    v = (sfull > SMax) || (sfull < SMin);
  endfunction

  function automatic void do_add(input logic [31:0] x, input logic [31:0] y, input logic ci,
                                 output logic [31:0] r, output logic c, output logic v);
    longint full, sfull;
    full  = longint'(x) + longint'(y) + longint'(ci);
    sfull = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    r = full[31:0];
    c = (full > 64'sd4294967295);
    v = (sfull > SMax) || (sfull < SMin);
  endfunction

  function automatic void alu_model(input in_t x, input logic [3:0] f,
                                    output logic [31:0] r, output logic [3:0] nf);
    logic c, v, arith;
    arith = 1'b1;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (x.op)
      2, 10: do_sub(x.a, x.b, 1'b0, r, c, v);
      3:     do_sub(x.b, x.a, 1'b0, r, c, v);
      4, 11: do_add(x.a, x.b, 1'b0, r, c, v);
      5:     do_add(x.a, x.b, f[1], r, c, v);
      6:     do_sub(x.a, x.b, !f[1], r, c, v);
      7:     do_sub(x.b, x.a, !f[1], r, c, v);
      default: begin
        arith = 1'b0;
        case (x.op)
          0, 8:    r = x.a & x.b;
          1, 9:    r = x.a ^ x.b;
          12:      r = x.a | x.b;
          13:      r = x.b;
          14:      r = x.a & ~x.b;
          default: r = ~x.b;
        endcase
      end
    endcase
    nf = {r[31], r == 32'd0, arith ? c : x.shc, arith ? v : f[0]};
  endfunction

  function automatic st_t model_next(input st_t s, input in_t x);
    st_t n;
    logic ok;
    logic [31:0] r;
    logic [3:0] nf;
    n = s;
    if (x.flush) begin
      n = '{default: '0};
      n.flags = s.flags;
    end else if (!x.stall) begin
      ok = cond_model(x.cond, s.flags);
      alu_model(x, s.flags, r, nf);
      n.res = r;
      n.sd  = x.sd;
      n.rd  = x.rd;
      n.rf  = x.rf && ok && !(x.op >= 8 && x.op <= 11);
      n.ld  = x.ld;
      n.sz  = x.sz;
      n.en  = x.en && ok;
      n.rw  = x.rw;
      if (x.s && ok) n.flags = nf;
    end
    return n;
  endfunction

  task automatic drive(input in_t x);
    cur = x;
    Flush            = x.flush;
    Stall            = x.stall;
    bus.ALU_In       = x.op;
    bus.S_In         = x.s;
    bus.rf_In        = x.rf;
    bus.Load_In      = x.ld;
    bus.Size_In      = x.sz;
    bus.Enable_In    = x.en;
    bus.rw_In        = x.rw;
    bus.Cond_In      = x.cond;
    bus.A_In         = x.a;
    bus.B_In         = x.b;
    bus.Shift_C_In   = x.shc;
    bus.StoreData_In = x.sd;
    bus.Rd_In        = x.rd;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".result"}, bus.ALU_Result_Out, m.res);
    chk({tag, ".sdata"},  bus.StoreData_Out,  m.sd);
    chk({tag, ".rd"},     {28'd0, bus.Rd_Out}, {28'd0, m.rd});
    chk({tag, ".rf"},     {31'd0, bus.rf_Out}, {31'd0, m.rf});
    chk({tag, ".load"},   {31'd0, bus.Load_Out}, {31'd0, m.ld});
    chk({tag, ".size"},   {31'd0, bus.Size_Out}, {31'd0, m.sz});
    chk({tag, ".en"},     {31'd0, bus.Enable_Out}, {31'd0, m.en});
    chk({tag, ".rw"},     {31'd0, bus.rw_Out}, {31'd0, m.rw});
    chk({tag, ".flags"},  {28'd0, bus.Flags_Out}, {28'd0, m.flags});
  endtask

  // Model predicts from pre-edge state; outputs sampled 1 ns after the edge.
  task automatic step(input string tag);
    st_t nx;
    nx = model_next(m, cur);
    @(posedge CLK);
    #1;
    m = nx;
    compare_all(tag);
  endtask

  function automatic in_t mk(input logic [3:0] op, input logic [3:0] cond, input logic s,
                             input logic rf, input logic [31:0] a, input logic [31:0] b,
                             input logic shc);
    in_t x;
    x = '{default: '0};
    x.op = op; x.cond = cond; x.s = s; x.rf = rf; x.a = a; x.b = b; x.shc = shc;
    x.en = 1'b1; x.sz = 1'b1; x.ld = 1'b0; x.rw = 1'b0; x.rd = 4'd3; x.sd = a ^ b;
    return x;
  endfunction

  function automatic in_t rnd_in();
    in_t x;
    x.op    = 4'($urandom_range(0, 15));
    x.cond  = ($urandom_range(0, 1) == 0) ? 4'he : 4'($urandom_range(0, 15));
    x.rd    = 4'($urandom_range(0, 15));
    x.s     = 1'($urandom_range(0, 1));
    x.rf    = 1'($urandom_range(0, 1));
    x.ld    = 1'($urandom_range(0, 1));
    x.sz    = 1'($urandom_range(0, 1));
    x.en    = 1'($urandom_range(0, 1));
    x.rw    = 1'($urandom_range(0, 1));
    x.shc   = 1'($urandom_range(0, 1));
    x.a     = ($urandom_range(0, 7) == 0) ? 32'h7fffffff : $urandom;
    x.b     = ($urandom_range(0, 7) == 0) ? 32'h00000001 : $urandom;
    x.sd    = $urandom;
    x.flush = 1'b0;
    x.stall = 1'b0;
    return x;
  endfunction

  task automatic add_vec(input in_t x, input logic [31:0] res, input logic [3:0] flags,
                         input logic rf, input logic en);
    vec_t v;
    v.in = x; v.res = res; v.flags = flags; v.rf = rf; v.en = en;
    tbl.push_back(v);
  endtask

  initial begin
    st_t  snap;
    in_t  x;

    // Opcode/condition encodings: ADD=4 SUB=2 RSB=3 ADC=5 SBC=6 AND=0 TEQ=9 CMP=10
    // MOV=13 MVN=15; EQ=0 NE=1 LT=11 AL=14 NV=15.
    add_vec(mk(4'd4,  4'he, 1, 1, 32'h7fffffff, 32'h1, 0), 32'h80000000, 4'b1001, 1, 1);
    add_vec(mk(4'd10, 4'he, 1, 1, 32'd5, 32'd5, 0),        32'h0,        4'b0110, 0, 1);
    add_vec(mk(4'd13, 4'h0, 0, 1, 32'd0, 32'h12, 0),       32'h12,       4'b0110, 1, 1);
    add_vec(mk(4'd2,  4'h1, 1, 1, 32'd9, 32'd1, 0),        32'h8,        4'b0110, 0, 0);
    add_vec(mk(4'd4,  4'he, 1, 1, 32'd0, 32'd0, 0),        32'h0,        4'b0100, 1, 1);
    add_vec(mk(4'd6,  4'he, 1, 1, 32'd0, 32'd0, 0),        32'hffffffff, 4'b1000, 1, 1);
    add_vec(mk(4'd4,  4'he, 1, 1, 32'h7fffffff, 32'h1, 0), 32'h80000000, 4'b1001, 1, 1);
    add_vec(mk(4'd0,  4'he, 1, 1, 32'hffff, 32'd0, 1),     32'h0,        4'b0111, 1, 1);
    add_vec(mk(4'd4,  4'hf, 1, 1, 32'd1, 32'd1, 0),        32'h2,        4'b0111, 0, 0);
    add_vec(mk(4'd3,  4'he, 1, 1, 32'd3, 32'd1, 0),        32'hfffffffe, 4'b1000, 1, 1);
    add_vec(mk(4'd9,  4'he, 1, 1, 32'hf0, 32'hf0, 0),      32'h0,        4'b0100, 0, 1);
    add_vec(mk(4'd5,  4'he, 1, 1, 32'hffffffff, 32'd0, 0), 32'hffffffff, 4'b1000, 1, 1);
    add_vec(mk(4'd15, 4'hb, 1, 1, 32'd0, 32'd0, 1),        32'hffffffff, 4'b1010, 1, 1);

    // Reset: outputs must be zero while CLR is held.
    CLR = 1'b1;
    m = '{default: '0};
    drive(mk(4'd0, 4'he, 0, 0, 32'd0, 32'd0, 0));
    #2;
    compare_all("reset");
    #15 CLR = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.res_const", i), bus.ALU_Result_Out, tbl[i].res);
      chk($sformatf("tbl%0d.flags_const", i), {28'd0, bus.Flags_Out}, {28'd0, tbl[i].flags});
      chk($sformatf("tbl%0d.rf_const", i), {31'd0, bus.rf_Out}, {31'd0, tbl[i].rf});
      chk($sformatf("tbl%0d.en_const", i), {31'd0, bus.Enable_Out}, {31'd0, tbl[i].en});
    end

    // Stall for 3 cycles with changing inputs: everything frozen.
    drive(mk(4'd4, 4'he, 1, 1, 32'h11, 32'h22, 0));
    step("preload");
    snap = m;
    for (int i = 0; i < 3; i++) begin
      x = rnd_in();
      x.stall = 1'b1;
      x.cond  = 4'he;
      x.s     = 1'b1;
      drive(x);
      step($sformatf("stall%0d", i));
      chk($sformatf("stall%0d.frozen_res", i), bus.ALU_Result_Out, snap.res);
      chk($sformatf("stall%0d.frozen_flags", i), {28'd0, bus.Flags_Out}, {28'd0, snap.flags});
    end

    // Flush with Stall: bubble, flags kept.
    x = mk(4'd4, 4'he, 1, 1, 32'h7fffffff, 32'h1, 0);
    x.flush = 1'b1;
    x.stall = 1'b1;
    drive(x);
    step("flush_stall");
    chk("flush_stall.rf0", {31'd0, bus.rf_Out}, 32'd0);
    chk("flush_stall.en0", {31'd0, bus.Enable_Out}, 32'd0);
    chk("flush_stall.flags_kept", {28'd0, bus.Flags_Out}, {28'd0, snap.flags});

    // CLR pulse away from the clock edge clears at once.
    drive(mk(4'd4, 4'he, 1, 1, 32'hffffffff, 32'h1, 0));
    step("pre_clr");
    #3 CLR = 1'b1;
    #1;
    m = '{default: '0};
    compare_all("clr_mid");
    #2 CLR = 1'b0;
    step("post_clr");

    // CLR during a stall, then a normal load.
    x = rnd_in();
    x.stall = 1'b1;
    drive(x);
    step("stall_pre_clr");
    #3 CLR = 1'b1;
    #1;
    m = '{default: '0};
    compare_all("clr_in_stall");
    #2 CLR = 1'b0;
    drive(mk(4'd13, 4'he, 1, 1, 32'd0, 32'h80000000, 1));
    step("load_after_clr");
    chk("load_after_clr.res_const", bus.ALU_Result_Out, 32'h80000000);
    chk("load_after_clr.flags_const", {28'd0, bus.Flags_Out}, 32'h0000000a);

    // Random traffic with occasional flushes and stalls.
    for (int i = 0; i < 400; i++) begin
      x = rnd_in();
      x.flush = ($urandom_range(0, 9) == 0);
      x.stall = ($urandom_range(0, 7) == 0);
      drive(x);
      step($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
